tick_scheduler: RTL
===================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter BASE_DIV, default 50000, clk cycles per base tick (1 kHz at 50 MHz); the block SHALL support BASE_DIV >= 2.
REQ-002 clk  in  1  system clock, 50 MHz.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 pause  in  1  freezes the prescaler and all channel counters while high.
REQ-005 cfg_valid  in  1  configuration request.
REQ-006 cfg_ready  out  1  configuration slot free; a transfer occurs when cfg_valid and cfg_ready are both high.
REQ-007 cfg_chan  in  2  target channel, 0-3.
REQ-008 cfg_period  in  10  channel period, in base ticks.
REQ-009 cfg_en  in  1  channel enable.
REQ-010 base_tick  out  1  one-cycle pulse, once every BASE_DIV unpaused cycles.
REQ-011 ev_valid  out  1  event slot holds a channel event.
REQ-012 ev_chan  out  2  channel of the held event.
REQ-013 ev_ready  in  1  consumer accepts the event.
REQ-014 pending  out  4  per-channel fired-but-not-yet-issued flags.
REQ-015 overrun  out  1  sticky flag: an event was lost.
REQ-016 clr_overrun  in  1  clears overrun.

Function
REQ-017 Prescaler counts 0..BASE_DIV-1 on each cycle with pause=0, then wraps to 0; base_tick SHALL be registered and high for exactly the cycle after the counter holds BASE_DIV-1.
REQ-018 While pause=1, the prescaler SHALL hold its value, base_tick SHALL be 0, and channel counters SHALL hold.
REQ-019 Per channel i, registers en, period[9:0] and cnt[9:0]; on base_tick with en=1 and period!=0: if cnt==period-1, cnt<=0 and the channel fires; otherwise cnt<=cnt+1.
REQ-020 A channel with en=0 or period=0 SHALL never fire, and its cnt SHALL hold.
REQ-021 Config FSM states: C_IDLE (cfg_ready=1) and C_APPLY (cfg_ready=0); an accepted transfer latches chan/period/en and moves to C_APPLY.
REQ-022 C_APPLY lasts one cycle: it writes en/period to the latched channel, sets its cnt<=0, clears its pending bit if en=0, then returns to C_IDLE.
REQ-023 On the C_APPLY cycle, the written channel SHALL NOT fire even if base_tick=1 (config wins); other channels SHALL be unaffected.
REQ-024 A fire sets pending[i]; if pending[i] is already 1 and not being cleared that cycle, overrun<=1.
REQ-025 Event FSM states: E_EMPTY (ev_valid=0) and E_HOLD (ev_valid=1).
REQ-026 In E_EMPTY with pending!=0, select a channel round-robin, searching from rr_ptr upward modulo 4; load ev_chan, clear that pending bit, set rr_ptr<=sel+1, and move to E_HOLD.
REQ-027 In E_HOLD, ev_chan SHALL remain stable; on ev_ready=1, return to E_EMPTY, giving a one-cycle bubble before the next event.
REQ-028 If a fire and a pending clear hit the same channel in one cycle, pending stays 1 and no overrun is flagged.
REQ-029 clr_overrun=1 clears overrun; if an overrun is set in the same cycle, set wins.
REQ-030 Worst-case latency from fire to ev_valid, slot empty and no other pending: 2 cycles (pending set, then slot load).

Reset
REQ-031 On reset, the following SHALL hold: prescaler=0; base_tick=0; all en=0, period=0, cnt=0; pending=0; overrun=0; E_EMPTY with ev_valid=0 and ev_chan=0; rr_ptr=0; C_IDLE with cfg_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard held events and configuration immediately, with no event emitted after release until channels are reconfigured.
REQ-033 After release, the first base_tick SHALL occur BASE_DIV cycles after the first unpaused clk edge.

Verification
REQ-034 BASE_DIV=4, ch0 period=3 en=1, ev_ready=1 -> base_tick every 4 cycles; ev_valid with ev_chan=0 every 12 cycles.
REQ-035 BASE_DIV=4, ch1 and ch2 period=1, ev_ready=0 for 10 cycles then 1 -> ev_chan order 1,2,1,2...; pending shows 0110 while blocked.
REQ-036 ch0 period=1, ev_ready=0 held for 3 base ticks -> overrun=1 on the 3rd fire; one clr_overrun pulse -> overrun=0.
REQ-037 ch3 period=5 running, pause=1 for 20 cycles -> no base_tick and cnt frozen; counting resumes at the same cnt after pause=0.
REQ-038 Config ch0 period=2 arriving on a base_tick cycle -> cfg_ready low for 1 cycle, no fire that cycle, next fire 2 base ticks later; write en=0 while pending[0]=1 -> pending[0] cleared.
REQ-039 Reset asserted while in E_HOLD -> ev_valid=0 and pending=0 asynchronously; no ev_valid after release.

Source files
------------

// File: rtl/tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// tick_scheduler: prescaled base tick driving four periodic channels; fired channels are
// queued in a pending mask and issued round-robin through a one-deep event slot. Rev 1.0
module tick_scheduler #(
  parameter int BASE_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_chan,
  input  logic [9:0] cfg_period,
  input  logic       cfg_en,
  output logic       base_tick,
  output logic       ev_valid,
  output logic [1:0] ev_chan,
  input  logic       ev_ready,
  output logic [3:0] pending,
  output logic       overrun,
  input  logic       clr_overrun
);
  localparam int            PW         = $clog2(BASE_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(BASE_DIV - 1);

  typedef enum logic {C_IDLE = 1'b0, C_APPLY = 1'b1} cfg_state_t;
  typedef enum logic {E_EMPTY = 1'b0, E_HOLD = 1'b1} ev_state_t;

  cfg_state_t    cfg_state;
  ev_state_t     ev_state;
  logic [PW-1:0] presc;
  logic          tick_q;
  logic [3:0]    en;
  logic [9:0]    period [4];
  logic [9:0]    cnt    [4];
  logic [1:0]    rr_ptr;
  logic [1:0]    lat_chan;
  logic [9:0]    lat_period;
  logic          lat_en;
  logic [3:0]    fire;
  logic [3:0]    clr;
  logic [1:0]    sel;
  logic          sel_found;
  logic          set_ovr;

  // A tick pending when pause rises is held back and released on the first unpaused cycle.
  assign base_tick = tick_q & ~pause;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else if (!pause) begin
      tick_q <= (presc == PRESC_LAST);
      presc  <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  always_comb begin
    fire = '0;
    for (int i = 0; i < 4; i++) begin
      if (base_tick && en[i] && (period[i] != '0) && (cnt[i] == period[i] - 10'd1) &&
          !((cfg_state == C_APPLY) && (lat_chan == 2'(i))))
        fire[i] = 1'b1;
    end
  end

  // Descending scan so the smallest offset from rr_ptr is the one that sticks.
  always_comb begin
    sel       = rr_ptr;
    sel_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (pending[rr_ptr + 2'(k)]) begin
        sel       = rr_ptr + 2'(k);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    if ((ev_state == E_EMPTY) && sel_found)
      clr[sel] = 1'b1;
    if ((cfg_state == C_APPLY) && !lat_en)
      clr[lat_chan] = 1'b1;
  end

  assign set_ovr = |(fire & pending & ~clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en         <= '0;
      pending    <= '0;
      overrun    <= 1'b0;
      rr_ptr     <= '0;
      cfg_state  <= C_IDLE;
      cfg_ready  <= 1'b1;
      lat_chan   <= '0;
      lat_period <= '0;
      lat_en     <= 1'b0;
      ev_state   <= E_EMPTY;
      ev_valid   <= 1'b0;
      ev_chan    <= '0;
      for (int i = 0; i < 4; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (base_tick && en[i] && (period[i] != '0))
          cnt[i] <= fire[i] ? '0 : cnt[i] + 10'd1;
      end

      pending <= fire | (pending & ~clr);

      if (set_ovr)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;

      case (cfg_state)
        C_IDLE: begin
          if (cfg_valid) begin
            lat_chan   <= cfg_chan;
            lat_period <= cfg_period;
            lat_en     <= cfg_en;
            cfg_state  <= C_APPLY;
            cfg_ready  <= 1'b0;
          end
        end
        C_APPLY: begin
          // Placed after the counter update so the configuration write wins.
          en[lat_chan]     <= lat_en;
          period[lat_chan] <= lat_period;
          cnt[lat_chan]    <= '0;
          cfg_state        <= C_IDLE;
          cfg_ready        <= 1'b1;
        end
        default: begin
          cfg_state <= C_IDLE;
          cfg_ready <= 1'b1;
        end
      endcase

      case (ev_state)
        E_EMPTY: begin
          if (sel_found) begin
            ev_chan  <= sel;
            rr_ptr   <= sel + 2'd1;
            ev_state <= E_HOLD;
            ev_valid <= 1'b1;
          end
        end
        E_HOLD: begin
          if (ev_ready) begin
            ev_state <= E_EMPTY;
            ev_valid <= 1'b0;
          end
        end
        default: begin
          ev_state <= E_EMPTY;
          ev_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire
